// File: rtl/multicycle_datapath_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset core.
// Optional build macro: MULTICYCLE_PERF_CNT_EN (cycle/instruction counters).
package multicycle_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // R-type funct codes
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU control encodings, same as the existing control decoder
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Map an opcode/funct pair onto the ALU control field.
    function automatic logic [3:0] alu_ctrl_f(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] ctrl;
        ctrl = ALU_ADD;
        if (op == OP_RTYPE) begin
            case (fn)
                FN_ADD:  ctrl = ALU_ADD;
                FN_SUB:  ctrl = ALU_SUB;
                FN_AND:  ctrl = ALU_AND;
                FN_OR:   ctrl = ALU_OR;
                FN_SLT:  ctrl = ALU_SLT;
                default: ctrl = ALU_ADD;
            endcase
        end else begin
            ctrl = ALU_ADD;
        end
        return ctrl;
    endfunction

    // True for every instruction the core executes (halt handled separately).
    function automatic logic is_legal_f(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_datapath_if.sv
// Unified instruction/data memory port with a req/ready handshake.
// A transfer completes in the cycle where mem_req and mem_ready are both high.
interface multicycle_datapath_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/multicycle_datapath_regfile.sv
// 32 x XLEN register file: two combinational read ports, one write port,
// R0 reads as zero and ignores writes, whole array clears on reset.
module mc_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [4:0]      ra1_i,
    input  logic [4:0]      ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);
    logic [XLEN-1:0] regs_q [32];

    // Register array: synchronous clear, single write port, R0 never written.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end else begin
            regs_q[0] <= '0;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];
endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer over a
// shared datapath and a single stallable memory port.
// Optional build macro: MULTICYCLE_PERF_CNT_EN enables cycle_count/instr_count.
module multicycle_datapath
    import multicycle_pkg::*;
#(
    parameter int                XLEN     = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  CLK,
    input  logic                  rst,
    multicycle_datapath_if.master mem,
    output logic [ADDR_W-1:0]     pc_out,
    output logic                  wb_valid,
    output logic [4:0]            wb_addr,
    output logic [XLEN-1:0]       result,
    output logic                  halted,
    output logic                  illegal,
    output logic [31:0]           cycle_count,
    output logic [31:0]           instr_count
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, target_q, target_d;
    logic [31:0]       ir_q, ir_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [XLEN-1:0]   aluout_q, aluout_d, mdr_q, mdr_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              halted_q, halted_d, illegal_q, illegal_d;

    logic [5:0]        opcode_s, funct_s;
    logic [4:0]        rs_s, rt_s, rd_s;
    logic [XLEN-1:0]   imm_ext_s, rf_rd1_s, rf_rd2_s, ea_s, rf_wd_s;
    logic              rf_we_s, xfer_s;
    logic [4:0]        rf_wa_s;

    assign opcode_s  = ir_q[31:26];
    assign rs_s      = ir_q[25:21];
    assign rt_s      = ir_q[20:16];
    assign rd_s      = ir_q[15:11];
    assign funct_s   = ir_q[5:0];
    assign imm_ext_s = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
    assign xfer_s    = mem_req_q & mem.mem_ready;

    // ALU: add/sub wrap, slt is a signed compare at full width.
    function automatic logic [XLEN-1:0] alu_f(input logic [3:0] ctrl,
                                              input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
        logic [XLEN-1:0] r;
        case (ctrl)
            ALU_AND: r = x & y;
            ALU_OR:  r = x | y;
            ALU_ADD: r = x + y;
            ALU_SUB: r = x - y;
            ALU_SLT: r = ($signed(x) < $signed(y)) ? XLEN'(1'b1) : '0;
            default: r = x + y;
        endcase
        return r;
    endfunction

    mc_regfile #(.XLEN(XLEN)) u_regfile (
        .clk_i   (CLK),
        .rst_n_i (rst),
        .ra1_i   (rs_s),
        .ra2_i   (rt_s),
        .rd1_o   (rf_rd1_s),
        .rd2_o   (rf_rd2_s),
        .we_i    (rf_we_s),
        .wa_i    (rf_wa_s),
        .wd_i    (rf_wd_s)
    );

    // Next-state, datapath updates and registered-output next values.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        target_d   = target_q;
        aluout_d   = aluout_q;
        mdr_d      = mdr_q;
        illegal_d  = illegal_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        result_d   = result_q;
        rf_we_s    = 1'b0;
        rf_wa_s    = 5'd0;
        rf_wd_s    = '0;
        ea_s       = a_q + imm_q;

        case (state_q)
            FETCH: begin
                if (xfer_s) begin
                    ir_d    = mem.mem_rdata[31:0];
                    pc_d    = pc_q + ADDR_W'(3'd4);
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                a_d      = rf_rd1_s;
                b_d      = rf_rd2_s;
                imm_d    = imm_ext_s;
                target_d = pc_q + {imm_ext_s[ADDR_W-3:0], 2'b00};
                if (opcode_s == OP_HALT) begin
                    state_d = HALT;
                end else if (!is_legal_f(opcode_s, funct_s)) begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (opcode_s)
                    OP_RTYPE: begin
                        if (funct_s == FN_JR) begin
                            pc_d    = a_q[ADDR_W-1:0];
                            state_d = FETCH;
                        end else begin
                            aluout_d = alu_f(alu_ctrl_f(opcode_s, funct_s), a_q, b_q);
                            state_d  = WB;
                        end
                    end
                    OP_ADDI: begin
                        aluout_d = alu_f(ALU_ADD, a_q, imm_q);
                        state_d  = WB;
                    end
                    OP_LW, OP_SW: begin
                        aluout_d = ea_s;
                        if (ea_s[1:0] != 2'b00) begin
                            state_d   = HALT;
                            illegal_d = 1'b1;
                        end else begin
                            state_d = MEM;
                        end
                    end
                    OP_BEQ: begin
                        pc_d    = (a_q == b_q) ? target_q : pc_q;
                        state_d = FETCH;
                    end
                    OP_J: begin
                        pc_d    = {pc_q[ADDR_W-1:28], ir_q[25:0], 2'b00};
                        state_d = FETCH;
                    end
                    OP_JAL: begin
                        // Link value is the PC already advanced past the jal.
                        pc_d       = {pc_q[ADDR_W-1:28], ir_q[25:0], 2'b00};
                        rf_we_s    = 1'b1;
                        rf_wa_s    = 5'd31;
                        rf_wd_s    = XLEN'(pc_q);
                        wb_valid_d = 1'b1;
                        wb_addr_d  = 5'd31;
                        result_d   = XLEN'(pc_q);
                        state_d    = FETCH;
                    end
                    default: begin
                        state_d   = HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEM: begin
                if (xfer_s) begin
                    if (opcode_s == OP_SW) begin
                        state_d = FETCH;
                    end else begin
                        mdr_d   = mem.mem_rdata;
                        state_d = WB;
                    end
                end else begin
                    state_d = MEM;
                end
            end
            WB: begin
                rf_we_s    = 1'b1;
                rf_wa_s    = (opcode_s == OP_RTYPE) ? rd_s : rt_s;
                rf_wd_s    = (opcode_s == OP_LW) ? mdr_q : aluout_q;
                wb_valid_d = 1'b1;
                wb_addr_d  = rf_wa_s;
                result_d   = rf_wd_s;
                state_d    = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d   = HALT;
                illegal_d = 1'b1;
            end
        endcase

        // Memory outputs are set up one cycle ahead so they are flop-driven
        // and stay constant for the entire request, including wait cycles.
        mem_req_d  = (state_d == FETCH) || (state_d == MEM);
        mem_we_d   = (state_d == MEM) && (opcode_s == OP_SW);
        mem_addr_d = (state_d == MEM) ? aluout_d[ADDR_W-1:0] : pc_d;
        if ((state_d == MEM) && (opcode_s == OP_SW)) begin
            mem_wdata_d = b_q;
        end else begin
            mem_wdata_d = mem_wdata_q;
        end
        halted_d = (state_d == HALT);
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: PC, IR, operand latches, ALUOut, MDR.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            target_q <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            target_q <= target_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
        end
    end

    // Registered outputs: memory port, retirement report and status flags.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= RESET_PC;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= 5'd0;
            result_q    <= '0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            result_q    <= result_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign pc_out        = pc_q;
    assign wb_valid      = wb_valid_q;
    assign wb_addr       = wb_addr_q;
    assign result        = result_q;
    assign halted        = halted_q;
    assign illegal       = illegal_q;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;

    // Performance counters: live cycles, and instructions that return to FETCH.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= halted_q ? cycle_cnt_q : cycle_cnt_q + 32'd1;
            instr_cnt_q <= ((state_q != FETCH) && (state_d == FETCH)) ?
                           instr_cnt_q + 32'd1 : instr_cnt_q;
        end
    end

    assign cycle_count = cycle_cnt_q;
    assign instr_count = instr_cnt_q;
`else
    assign cycle_count = 32'd0;
    assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: behavioural memory with
// programmable wait states, table-driven ALU/writeback vectors and
// hand-written sequences for memory, branch, jump, fault and reset cases.
module tb_multicycle_datapath;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

    localparam logic [5:0] T_ADDI = 6'h08, T_LW = 6'h23, T_SW = 6'h2B;
    localparam logic [5:0] T_BEQ = 6'h04, T_JAL = 6'h03;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24;
    localparam logic [5:0] F_OR = 6'h25, F_SLT = 6'h2A, F_JR = 6'h08;
    localparam logic [31:0] I_HALT = 32'hFC00_0000;

    logic CLK = 1'b0;
    logic rst = 1'b0;
    always #5 CLK = ~CLK;

    multicycle_datapath_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) mif ();

    logic [ADDR_W-1:0] pc_out;
    logic              wb_valid, halted, illegal;
    logic [4:0]        wb_addr;
    logic [XLEN-1:0]   result;
    logic [31:0]       cycle_count, instr_count;

    multicycle_datapath #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .rst(rst), .mem(mif),
        .pc_out(pc_out), .wb_valid(wb_valid), .wb_addr(wb_addr), .result(result),
        .halted(halted), .illegal(illegal),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; int cyc; } xfer_t;
    typedef struct { logic [4:0] a; logic [31:0] d; } wbrec_t;
    typedef struct { logic [31:0] instr; logic [4:0] exp_a; logic [31:0] exp_d; } vec_t;

    logic [31:0] mem_arr [0:63];
    xfer_t       xq [$];
    wbrec_t      wq [$];
    int          cyc = 0, wait_cfg = 0, wait_cnt = 0, addr_bad = 0, req_after_halt = 0;
    logic [31:0] first_addr = 32'd0, lat_addr = 32'd0, lat_wdata = 32'd0;
    logic        lat_we = 1'b0;
    int          total = 0, passed = 0;

    always @(posedge CLK) cyc = cyc + 1;

    // Memory model and observers, all acting on the falling edge.
    always @(negedge CLK) begin
        if (mif.mem_ready) begin
            if (lat_we) mem_arr[lat_addr[7:2]] = lat_wdata;
            xq.push_back('{lat_addr, lat_we, lat_wdata, cyc});
            wait_cnt = 0;
        end
        mif.mem_ready = 1'b0;
        if (!rst) begin
            wait_cnt = 0;
        end else if (mif.mem_req) begin
            if (wait_cnt == 0) first_addr = mif.mem_addr;
            else if (mif.mem_addr != first_addr) addr_bad++;
            if (wait_cnt >= wait_cfg) begin
                mif.mem_ready = 1'b1;
                mif.mem_rdata = mem_arr[mif.mem_addr[7:2]];
                lat_addr  = mif.mem_addr;
                lat_we    = mif.mem_we;
                lat_wdata = mif.mem_wdata;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        if (wb_valid) wq.push_back('{wb_addr, result});
        if (halted && mif.mem_req) req_after_halt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem_arr[i] = I_HALT;
    endtask

    // Hold reset for two edges, clear logs, release on a falling edge.
    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        xq.delete(); wq.delete();
        addr_bad = 0; req_after_halt = 0;
        rst = 1'b1;
    endtask

    task automatic run_to_halt(input int maxc);
        for (int n = 0; n < maxc && !halted; n++) begin
            @(negedge CLK); #1;
        end
        chk("halt_reached", halted, 1'b1);
    endtask

    vec_t vt [10];

    initial begin
        // ---------------- Table-driven ALU / writeback program ----------------
        vt[0] = '{enc_i(T_ADDI, 5'd0, 5'd1, 16'd5),      5'd1,  32'd5};
        vt[1] = '{enc_i(T_ADDI, 5'd0, 5'd2, 16'hFFFD),   5'd2,  32'hFFFF_FFFD};
        vt[2] = '{enc_r(5'd1, 5'd2, 5'd3, F_ADD),        5'd3,  32'd2};
        vt[3] = '{enc_r(5'd2, 5'd1, 5'd5, F_SUB),        5'd5,  32'hFFFF_FFF8};
        vt[4] = '{enc_r(5'd1, 5'd2, 5'd6, F_AND),        5'd6,  32'd5};
        vt[5] = '{enc_r(5'd1, 5'd2, 5'd7, F_OR),         5'd7,  32'hFFFF_FFFD};
        vt[6] = '{enc_r(5'd2, 5'd1, 5'd8, F_SLT),        5'd8,  32'd1};
        vt[7] = '{enc_r(5'd1, 5'd2, 5'd9, F_SLT),        5'd9,  32'd0};
        vt[8] = '{enc_r(5'd1, 5'd1, 5'd0, F_ADD),        5'd0,  32'd10};
        vt[9] = '{enc_r(5'd0, 5'd0, 5'd10, F_ADD),       5'd10, 32'd0};

        clear_mem();
        for (int i = 0; i < 10; i++) mem_arr[i] = vt[i].instr;
        wait_cfg = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        chk("rst_mem_req", mif.mem_req, 1'b0);
        chk("rst_mem_we", mif.mem_we, 1'b0);
        chk("rst_mem_wdata", mif.mem_wdata, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_addr", wb_addr, 5'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        do_reset();
        run_to_halt(300);
        chk("alu_illegal", illegal, 1'b0);
        chk("alu_wb_count", wq.size(), 10);
        for (int i = 0; i < 10 && i < wq.size(); i++) begin
            chk($sformatf("alu_wb_addr[%0d]", i), wq[i].a, vt[i].exp_a);
            chk($sformatf("alu_wb_data[%0d]", i), wq[i].d, vt[i].exp_d);
        end
        if (xq.size() >= 4) begin
            chk("alu_fetch3_addr", xq[3].addr, 32'hC);
            chk("three_instr_cycles", xq[3].cyc - xq[0].cyc, 12);
        end else chk("alu_fetch_count", xq.size(), 11);

        // ---------------- sw / lw with three wait states ----------------
        clear_mem();
        mem_arr[0] = enc_i(T_ADDI, 5'd0, 5'd3, 16'd2);
        mem_arr[1] = enc_i(T_SW, 5'd0, 5'd3, 16'h40);
        mem_arr[2] = enc_i(T_LW, 5'd0, 5'd4, 16'h40);
        mem_arr[16] = 32'hDEAD_BEEF;
        wait_cfg = 3;
        do_reset();
        run_to_halt(400);
        chk("mem_xfer_count", xq.size(), 6);
        if (xq.size() >= 6) begin
            chk("sw_we", xq[2].we, 1'b1);
            chk("sw_addr", xq[2].addr, 32'h40);
            chk("sw_wdata", xq[2].wdata, 32'd2);
            chk("lw_we", xq[4].we, 1'b0);
            chk("lw_addr", xq[4].addr, 32'h40);
            chk("lw_latency_waits", xq[5].cyc - xq[3].cyc, 11);
        end
        chk("mem_wb_count", wq.size(), 2);
        if (wq.size() >= 2) begin
            chk("lw_wb_addr", wq[1].a, 5'd4);
            chk("lw_wb_data", wq[1].d, 32'd2);
        end
        chk("addr_stable", addr_bad, 0);
        chk("mem_illegal", illegal, 1'b0);

        // ---------------- Branches, jal, jr ----------------
        clear_mem();
        mem_arr[0]  = enc_i(T_ADDI, 5'd0, 5'd1, 16'd5);
        mem_arr[1]  = enc_i(T_ADDI, 5'd0, 5'd2, 16'd7);
        mem_arr[2]  = enc_i(T_ADDI, 5'd0, 5'd3, 16'd1);
        mem_arr[3]  = enc_i(T_ADDI, 5'd0, 5'd3, 16'd1);
        mem_arr[4]  = enc_i(T_BEQ, 5'd1, 5'd1, 16'd2);
        mem_arr[7]  = enc_i(T_BEQ, 5'd1, 5'd2, 16'd5);
        mem_arr[8]  = {T_JAL, 26'h10};
        mem_arr[16] = enc_r(5'd31, 5'd0, 5'd0, F_JR);
        wait_cfg = 0;
        do_reset();
        run_to_halt(300);
        begin
            logic [31:0] exp_f [9];
            exp_f = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h1C, 32'h20, 32'h40, 32'h24};
            chk("br_fetch_count", xq.size(), 9);
            for (int i = 0; i < 9 && i < xq.size(); i++)
                chk($sformatf("br_fetch[%0d]", i), xq[i].addr, exp_f[i]);
            if (xq.size() >= 6) chk("beq_latency", xq[5].cyc - xq[4].cyc, 3);
        end
        chk("br_wb_count", wq.size(), 5);
        if (wq.size() >= 5) begin
            chk("jal_wb_addr", wq[4].a, 5'd31);
            chk("jal_wb_data", wq[4].d, 32'h24);
        end

        // ---------------- Misaligned lw, then reset restart ----------------
        clear_mem();
        mem_arr[0] = enc_i(T_LW, 5'd0, 5'd5, 16'd6);
        do_reset();
        run_to_halt(100);
        chk("mis_illegal", illegal, 1'b1);
        chk("mis_xfer_count", xq.size(), 1);
        repeat (10) begin @(negedge CLK); #1; end
        chk("mis_no_req_after_halt", req_after_halt, 0);
        chk("mis_wb_count", wq.size(), 0);
        rst = 1'b0;
        @(negedge CLK); #1;
        chk("mis_rst_pc", pc_out, 32'd0);
        chk("mis_rst_halted", halted, 1'b0);
        chk("mis_rst_illegal", illegal, 1'b0);
        chk("mis_rst_req", mif.mem_req, 1'b0);
        xq.delete();
        rst = 1'b1;
        for (int n = 0; n < 20 && xq.size() == 0; n++) begin @(negedge CLK); #1; end
        chk("restart_fetch_seen", xq.size() > 0, 1'b1);
        if (xq.size() > 0) chk("restart_fetch_addr", xq[0].addr, 32'h0);

        // ---------------- Illegal opcode ----------------
        clear_mem();
        mem_arr[0] = 32'h0400_0000;
        do_reset();
        run_to_halt(100);
        chk("badop_illegal", illegal, 1'b1);
        chk("badop_wb_count", wq.size(), 0);

        // ---------------- Reset during a FETCH wait state ----------------
        clear_mem();
        mem_arr[0] = enc_i(T_ADDI, 5'd0, 5'd1, 16'd9);
        mem_arr[1] = enc_i(T_ADDI, 5'd0, 5'd2, 16'd4);
        mem_arr[2] = enc_r(5'd1, 5'd2, 5'd11, F_ADD);
        wait_cfg = 4;
        do_reset();
        for (int n = 0; n < 200 && wq.size() < 1; n++) begin @(negedge CLK); #1; end
        chk("pre_rst_wb", wq.size(), 1);
        chk("in_fetch_wait", {mif.mem_req, mif.mem_ready}, 2'b10);
        rst = 1'b0;
        @(negedge CLK); #1;
        chk("midrst_req", mif.mem_req, 1'b0);
        chk("midrst_pc", pc_out, 32'd0);
        chk("midrst_wb_valid", wb_valid, 1'b0);
        chk("midrst_cycle_count", cycle_count, 32'd0);
        chk("midrst_instr_count", instr_count, 32'd0);
        clear_mem();
        mem_arr[0] = enc_r(5'd1, 5'd2, 5'd11, F_ADD);
        wait_cfg = 0;
        @(negedge CLK); #1;
        xq.delete(); wq.delete();
        rst = 1'b1;
        run_to_halt(100);
        chk("cleared_wb_count", wq.size(), 1);
        if (wq.size() >= 1) begin
            chk("cleared_wb_addr", wq[0].a, 5'd11);
            chk("cleared_regs_sum", wq[0].d, 32'd0);
        end
`ifdef MULTICYCLE_PERF_CNT_EN
        chk("perf_cycle_count", cycle_count, 32'd7);
        chk("perf_instr_count", instr_count, 32'd1);
`else
        chk("perf_cycle_tied", cycle_count, 32'd0);
        chk("perf_instr_tied", instr_count, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
